// File: rtl/corr_window_seq_pkg.sv
// Shared definitions for the correlation window sequencer.
//   seq_state_e : sequencer FSM states (idle, one-cycle prime, running windows)
//   SEQ_W       : width of the snapshot sequence number
package corr_window_seq_pkg;

   localparam int unsigned SEQ_W = 8;

   typedef enum logic [1:0] {
      StIdle,
      StPrime,
      StRun
   } seq_state_e;

endpackage

// File: rtl/corr_window_seq_if.sv
// Snapshot handshake bundle between the window sequencer and its consumer.
//   o_pktValid / i_pktReady : valid/ready handshake
//   o_pktX/Y/Isect/Symdiff  : counts of the completed window
//   o_pktSeq                : snapshot sequence number
//   o_pktExp                : window exponent that applied to the snapshot
// master = producer (sequencer), slave = consumer.
interface corr_window_seq_if
   import corr_window_seq_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned EXP_W  = 4
) ();

   logic              o_pktValid;
   logic              i_pktReady;
   logic [DATA_W-1:0] o_pktX;
   logic [DATA_W-1:0] o_pktY;
   logic [DATA_W-1:0] o_pktIsect;
   logic [DATA_W-1:0] o_pktSymdiff;
   logic [SEQ_W-1:0]  o_pktSeq;
   logic [EXP_W-1:0]  o_pktExp;

   modport master (
      output o_pktValid, o_pktX, o_pktY, o_pktIsect, o_pktSymdiff, o_pktSeq, o_pktExp,
      input  i_pktReady
   );

   modport slave (
      input  o_pktValid, o_pktX, o_pktY, o_pktIsect, o_pktSymdiff, o_pktSeq, o_pktExp,
      output i_pktReady
   );

endinterface

// File: rtl/corr_snapshot_buf.sv
// One-deep valid/ready snapshot register for the four window counts plus
// sequence number and exponent. Tracks lost snapshots in a sticky flag.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_cg                : clock-gate enable, all state holds when 0
//   i_capture           : load request from the sequencer (boundary cycle)
//   i_x..i_symdiff      : counts to capture
//   i_exp               : exponent of the window just ended
//   i_clrDropped        : clears o_dropped (a simultaneous drop wins)
//   o_dropped           : sticky lost-snapshot flag
//   pkt                 : snapshot handshake (master side)
module corr_snapshot_buf
   import corr_window_seq_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned EXP_W  = 4
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cg,
   input  logic              i_capture,
   input  logic [DATA_W-1:0] i_x,
   input  logic [DATA_W-1:0] i_y,
   input  logic [DATA_W-1:0] i_isect,
   input  logic [DATA_W-1:0] i_symdiff,
   input  logic [EXP_W-1:0]  i_exp,
   input  logic              i_clrDropped,
   output logic              o_dropped,
   corr_window_seq_if.master pkt
);

   logic              valid_q;
   logic              dropped_q;
   logic [DATA_W-1:0] x_q, y_q, isect_q, symdiff_q;
   logic [SEQ_W-1:0]  seq_q;
   logic [SEQ_W-1:0]  seq_next_q;
   logic [EXP_W-1:0]  exp_q;
   logic              xfer;
   logic              load;
   logic              drop;

   assign xfer = valid_q & pkt.i_pktReady;
   // A transfer in the capture cycle frees the slot, so the new snapshot still fits.
   assign load = i_capture & (~valid_q | xfer);
   assign drop = i_capture & valid_q & ~xfer;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q    <= 1'b0;
         dropped_q  <= 1'b0;
         x_q        <= '0;
         y_q        <= '0;
         isect_q    <= '0;
         symdiff_q  <= '0;
         seq_q      <= '0;
         seq_next_q <= '0;
         exp_q      <= '0;
      end else if (i_cg) begin
         if (load) begin
            valid_q    <= 1'b1;
            x_q        <= i_x;
            y_q        <= i_y;
            isect_q    <= i_isect;
            symdiff_q  <= i_symdiff;
            exp_q      <= i_exp;
            seq_q      <= seq_next_q;
            seq_next_q <= seq_next_q + SEQ_W'(1);
         end else if (xfer) begin
            valid_q <= 1'b0;
         end
         if (drop) begin
            dropped_q <= 1'b1;
         end else if (i_clrDropped) begin
            dropped_q <= 1'b0;
         end
      end
   end

   assign pkt.o_pktValid   = valid_q;
   assign pkt.o_pktX       = x_q;
   assign pkt.o_pktY       = y_q;
   assign pkt.o_pktIsect   = isect_q;
   assign pkt.o_pktSymdiff = symdiff_q;
   assign pkt.o_pktSeq     = seq_q;
   assign pkt.o_pktExp     = exp_q;
   assign o_dropped        = dropped_q;

endmodule

// File: rtl/corr_window_seq.sv
// Correlation window sequencer. Runs back-to-back windows of 2^exp cycles,
// drives the window time index and start pulse to the counter stage, and
// snapshots the counter stage's running counts at each window boundary.
//   i_clk, i_rst         : clock, asynchronous active-high reset
//   i_cg                 : clock-gate enable, all state holds when 0
//   i_enable             : 1 = run windows, 0 = idle
//   i_windowLengthExp    : window exponent, clamped to TIME_W
//   i_countX..Symdiff    : running counts from the counter stage
//   o_t                  : current window time index
//   o_zeroCounts         : window-start pulse
//   o_dropped            : sticky lost-snapshot flag, cleared by i_clrDropped
//   pkt                  : snapshot handshake (master side)
module corr_window_seq
   import corr_window_seq_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned TIME_W = 8,
   localparam int unsigned EXP_W = $clog2(TIME_W + 1)
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cg,
   input  logic              i_enable,
   input  logic [EXP_W-1:0]  i_windowLengthExp,
   input  logic [DATA_W-1:0] i_countX,
   input  logic [DATA_W-1:0] i_countY,
   input  logic [DATA_W-1:0] i_countIsect,
   input  logic [DATA_W-1:0] i_countSymdiff,
   output logic [TIME_W-1:0] o_t,
   output logic              o_zeroCounts,
   output logic              o_dropped,
   input  logic              i_clrDropped,
   corr_window_seq_if.master pkt
);

   seq_state_e        st_q, st_d;
   logic [TIME_W-1:0] t_q, t_d;
   logic [EXP_W-1:0]  exp_active_q, exp_active_d;
   logic [EXP_W-1:0]  exp_req;
   logic              boundary;
   logic              capture;

   // Last time index of a window of length 2^e (all-ones in the low e bits).
   function automatic logic [TIME_W-1:0] last_t(input logic [EXP_W-1:0] e);
      logic [TIME_W-1:0] ones;
      ones = '1;
      return ~(ones << e);
   endfunction

   assign exp_req = (i_windowLengthExp > EXP_W'(TIME_W)) ? EXP_W'(TIME_W) : i_windowLengthExp;

   // In RUN, t wraps to 0 only at a boundary, so t==0 identifies it.
   assign boundary = (st_q == StRun) && (t_q == '0);
   assign capture  = i_cg && boundary && i_enable;

   always_comb begin
      st_d         = st_q;
      t_d          = t_q;
      exp_active_d = exp_active_q;
      o_zeroCounts = 1'b0;
      unique case (st_q)
         StIdle: begin
            if (i_enable) begin
               st_d = StPrime;
            end
         end
         StPrime: begin
            o_zeroCounts = 1'b1;
            exp_active_d = exp_req;
            t_d          = (last_t(exp_req) == '0) ? '0 : TIME_W'(1);
            st_d         = StRun;
         end
         StRun: begin
            o_zeroCounts = boundary;
            if (!i_enable) begin
               st_d = StIdle;
               t_d  = '0;
            end else if (boundary) begin
               // New window starts here; it uses the freshly requested length.
               exp_active_d = exp_req;
               t_d          = (last_t(exp_req) == '0) ? '0 : TIME_W'(1);
            end else if (t_q == last_t(exp_active_q)) begin
               t_d = '0;
            end else begin
               t_d = t_q + TIME_W'(1);
            end
         end
         default: begin
            st_d = StIdle;
            t_d  = '0;
         end
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         st_q         <= StIdle;
         t_q          <= '0;
         exp_active_q <= '0;
      end else if (i_cg) begin
         st_q         <= st_d;
         t_q          <= t_d;
         exp_active_q <= exp_active_d;
      end
   end

   assign o_t = t_q;

   corr_snapshot_buf #(
      .DATA_W(DATA_W),
      .EXP_W (EXP_W)
   ) u_buf (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_cg        (i_cg),
      .i_capture   (capture),
      .i_x         (i_countX),
      .i_y         (i_countY),
      .i_isect     (i_countIsect),
      .i_symdiff   (i_countSymdiff),
      .i_exp       (exp_active_q),
      .i_clrDropped(i_clrDropped),
      .o_dropped   (o_dropped),
      .pkt         (pkt)
   );

endmodule

// File: tb/tb_corr_window_seq.sv
// Self-checking bench for corr_window_seq: directed scenarios plus random
// stimulus, all compared every cycle against a window/queue reference model.
module tb_corr_window_seq;

   localparam int DATA_W = 16;
   localparam int TIME_W = 8;
   localparam int EXP_W  = $clog2(TIME_W + 1);

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              cg, en, clr, ready;
   logic [EXP_W-1:0]  wexp;
   logic [DATA_W-1:0] cx, cy, ci, cs;
   logic [TIME_W-1:0] t;
   logic              zc, dropped;

   corr_window_seq_if #(.DATA_W(DATA_W), .EXP_W(EXP_W)) pkt_if ();
   assign pkt_if.i_pktReady = ready;

   corr_window_seq #(.DATA_W(DATA_W), .TIME_W(TIME_W)) dut (
      .i_clk            (clk),
      .i_rst            (rst),
      .i_cg             (cg),
      .i_enable         (en),
      .i_windowLengthExp(wexp),
      .i_countX         (cx),
      .i_countY         (cy),
      .i_countIsect     (ci),
      .i_countSymdiff   (cs),
      .o_t              (t),
      .o_zeroCounts     (zc),
      .o_dropped        (dropped),
      .i_clrDropped     (clr),
      .pkt              (pkt_if)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", tag, cyc, got, want);
      end
   endtask

   // Reference model: phase 0=idle 1=prime 2=run; pos = position inside the window.
   int m_phase, m_pos, m_len, m_exp;
   int m_x, m_y, m_i, m_s, m_seq, m_pexp, m_next_seq;
   bit m_valid, m_drop;

   task automatic model_reset();
      m_phase = 0; m_pos = 0; m_len = 1; m_exp = 0;
      m_x = 0; m_y = 0; m_i = 0; m_s = 0; m_seq = 0; m_pexp = 0; m_next_seq = 0;
      m_valid = 0; m_drop = 0;
   endtask

   task automatic model_step();
      int  e;
      bit  cap, xfer;
      if (!cg) return;
      e    = (int'(wexp) > TIME_W) ? TIME_W : int'(wexp);
      cap  = (m_phase == 2) && (m_pos == 0) && en;
      xfer = m_valid && ready;
      if (clr) m_drop = 0;
      if (cap && m_valid && !xfer) begin
         m_drop = 1;
      end else if (cap) begin
         m_x = int'(cx); m_y = int'(cy); m_i = int'(ci); m_s = int'(cs);
         m_pexp = m_exp;
         m_seq = m_next_seq;
         m_next_seq = (m_next_seq + 1) % 256;
         m_valid = 1;
      end else if (xfer) begin
         m_valid = 0;
      end
      case (m_phase)
         0: if (en) m_phase = 1;
         1: begin
            m_exp = e; m_len = 1 << e; m_pos = 1 % m_len; m_phase = 2;
         end
         default: begin
            if (!en) begin
               m_phase = 0; m_pos = 0;
            end else if (m_pos == 0) begin
               m_exp = e; m_len = 1 << e; m_pos = 1 % m_len;
            end else begin
               m_pos = (m_pos + 1) % m_len;
            end
         end
      endcase
   endtask

   task automatic compare();
      check("t", 64'(t), 64'(m_pos));
      check("zero_counts", 64'(zc), 64'((m_phase == 1) || (m_phase == 2 && m_pos == 0)));
      check("pkt_valid", 64'(pkt_if.o_pktValid), 64'(m_valid));
      check("pkt_x", 64'(pkt_if.o_pktX), 64'(m_x));
      check("pkt_y", 64'(pkt_if.o_pktY), 64'(m_y));
      check("pkt_isect", 64'(pkt_if.o_pktIsect), 64'(m_i));
      check("pkt_symdiff", 64'(pkt_if.o_pktSymdiff), 64'(m_s));
      check("pkt_seq", 64'(pkt_if.o_pktSeq), 64'(m_seq));
      check("pkt_exp", 64'(pkt_if.o_pktExp), 64'(m_pexp));
      check("dropped", 64'(dropped), 64'(m_drop));
   endtask

   task automatic tick();
      compare();
      @(posedge clk);
      model_step();
      @(negedge clk);
      cyc++;
   endtask

   task automatic rand_counts();
      cx = DATA_W'($urandom); cy = DATA_W'($urandom);
      ci = DATA_W'($urandom); cs = DATA_W'($urandom);
   endtask

   // Advance until the model reaches the wanted position; expiry counts as a failure.
   task automatic run_to_pos(input int pos, input bit need_valid, input string tag);
      bit hit = 0;
      for (int k = 0; k < 64; k++) begin
         if (m_phase == 2 && m_pos == pos && (!need_valid || m_valid)) begin
            hit = 1;
            break;
         end
         rand_counts();
         tick();
      end
      check(tag, 64'(hit), 64'(1));
   endtask

   initial begin
      cg = 1'b1; en = 1'b0; clr = 1'b0; ready = 1'b0; wexp = '0;
      cx = '0; cy = '0; ci = '0; cs = '0;
      model_reset();
      repeat (2) @(negedge clk);
      compare();
      rst = 1'b0;

      // exp=2, count X = cycle count, consumer always ready
      en = 1'b1; wexp = EXP_W'(2); ready = 1'b1;
      repeat (20) begin
         cx = DATA_W'(cyc);
         tick();
      end

      // exp=0: every RUN cycle is a boundary; enough cycles to wrap the sequence
      wexp = '0;
      repeat (300) begin
         rand_counts();
         tick();
      end

      // exp=3 with the consumer stalled across two boundaries, then clear the flag
      en = 1'b0; tick();
      en = 1'b1; wexp = EXP_W'(3); ready = 1'b0;
      repeat (20) begin
         rand_counts();
         tick();
      end
      clr = 1'b1; tick();
      clr = 1'b0; ready = 1'b1; tick();

      // exponent change 3->1 mid-window only takes effect at the next boundary
      run_to_pos(5, 1'b0, "reach_t5");
      wexp = EXP_W'(1);
      repeat (12) begin
         rand_counts();
         tick();
      end

      // clock gate low for 5 cycles mid-window
      wexp = EXP_W'(3);
      run_to_pos(2, 1'b0, "reach_t2");
      cg = 1'b0;
      repeat (5) begin
         rand_counts();
         tick();
      end
      cg = 1'b1;
      repeat (12) begin
         rand_counts();
         tick();
      end

      // asynchronous reset at t=3 while a snapshot is pending
      ready = 1'b0;
      run_to_pos(3, 1'b1, "reach_t3_valid");
      #2 rst = 1'b1;
      #1;
      model_reset();
      compare();
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0; en = 1'b1; ready = 1'b1;
      repeat (12) begin
         rand_counts();
         tick();
      end

      // random stimulus, mostly short windows with occasional clamped exponents
      repeat (3000) begin
         cg    = ($urandom_range(0, 9) != 0);
         en    = ($urandom_range(0, 29) != 0);
         ready = ($urandom_range(0, 2) != 0);
         clr   = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 31) == 0) wexp = EXP_W'($urandom_range(0, 15));
         else if ($urandom_range(0, 7) == 0) wexp = EXP_W'($urandom_range(0, 3));
         rand_counts();
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/corr_window_seq.md
CORR_WINDOW_SEQ -- requirements
Module: corr_window_seq

Interface
REQ-001 Parameter DATA_W, default 16: width of each correlation count.
REQ-002 Parameter TIME_W, default 8: width of the window time index; maximum window length is 2^TIME_W cycles.
REQ-003 i_clk  input  1: single clock; all state updates on its rising edge.
REQ-004 i_rst  input  1: reset, asynchronous, active-high.
REQ-005 i_cg  input  1: clock-gate enable; when 0, all state SHALL hold.
REQ-006 i_enable  input  1: 1 = run windows, 0 = idle.
REQ-007 i_windowLengthExp  input  $clog2(TIME_W+1): window length L = 2^exp cycles; values greater than TIME_W are clamped to TIME_W.
REQ-008 i_countX, i_countY, i_countIsect, i_countSymdiff  input  DATA_W each: running counts from the downstream counter stage.
REQ-009 o_t  output  TIME_W: current window time index, fed to the counter stage.
REQ-010 o_zeroCounts  output  1: window-start pulse, fed to the counter stage.
REQ-011 o_pktValid  output  1, and i_pktReady  input  1: snapshot handshake.
REQ-012 o_pktX, o_pktY, o_pktIsect, o_pktSymdiff  output  DATA_W each: snapshot of the completed window's counts.
REQ-013 o_pktSeq  output  8: snapshot sequence number.
REQ-014 o_pktExp  output  $clog2(TIME_W+1): window exponent that applied to the snapshot.
REQ-015 o_dropped  output  1: sticky lost-snapshot flag; i_clrDropped  input  1 clears it.

Function
REQ-016 States: IDLE, PRIME, RUN; every transition occurs only in cycles where i_cg=1.
REQ-017 IDLE: o_t=0, o_zeroCounts=0, no captures.
REQ-018 IDLE with i_enable=1 -> PRIME.
REQ-019 PRIME lasts 1 cycle: o_zeroCounts=1, o_t=0, the exponent is latched into expActive, and the state moves to RUN with t=1 (t=0 when L=1). No capture occurs in PRIME.
REQ-020 RUN: t increments by 1 per cycle.
REQ-021 RUN, t = L-1 reached: the next cycle is a boundary cycle with t=0.
REQ-022 Boundary cycle: o_zeroCounts=1, the snapshot of i_count* is captured (same edge), and expActive is updated from i_windowLengthExp.
REQ-023 L=1: every RUN cycle is a boundary cycle.
REQ-024 Changes to i_windowLengthExp SHALL take effect only at PRIME or a boundary cycle; mid-window changes are ignored.
REQ-025 RUN with i_enable=0 -> IDLE immediately; any partial window is discarded (no capture). A buffered snapshot is retained.
REQ-026 Capture: pkt* <= i_count*; o_pktExp <= the expActive of the window just ended; o_pktSeq increments by 1, wraps 255->0, and is 0 for the first snapshot after reset.
REQ-027 Buffer depth is 1.
REQ-028 o_pktValid rises on the cycle after capture.
REQ-029 A transfer occurs when o_pktValid=1 and i_pktReady=1; o_pktValid falls the next cycle unless a capture occurs in the same cycle.
REQ-030 Capture with buffer full and no transfer in the same cycle: the new snapshot is dropped, o_seq is not incremented, the existing buffer is unchanged, and o_dropped <= 1.
REQ-031 Capture and transfer in the same cycle: the new snapshot is loaded and o_pktValid stays 1.
REQ-032 o_pkt* and o_pktSeq SHALL be stable while o_pktValid=1 and i_pktReady=0.
REQ-033 i_clrDropped=1 in the same cycle as a new drop: the set wins.
REQ-034 Latency: snapshot data is visible at o_pkt* exactly 1 cycle after the boundary cycle.

Reset
REQ-035 Asynchronous assertion forces: state=IDLE, t=0, o_zeroCounts=0, o_pktValid=0, o_pkt*=0, o_pktSeq=0, o_pktExp=0, expActive=0, o_dropped=0.
REQ-036 Reset asserted mid-window or mid-handshake discards everything; operation restarts via PRIME.

Structure
REQ-037 The state enum and the sequence-number width (8) belong in the shared correlator package.
REQ-038 One sub-module, corr_snapshot_buf, holds the 1-deep valid/ready register for the four counts plus seq and exp; the sequencer FSM and t counter stay in the top module.
REQ-039 Total RTL SHALL be 120-400 lines.

Verification
REQ-040 exp=2, enable held, i_countX = cycle count: o_zeroCounts pulses every 4 cycles; o_t runs 0,1,2,3,0...; first o_pktSeq=0, pkt captured at the first boundary after PRIME.
REQ-041 exp=0: o_zeroCounts constantly 1 in RUN; i_pktReady=1 yields one snapshot per cycle with o_pktSeq incrementing and wrapping 255->0.
REQ-042 exp=3, i_pktReady=0 across two boundaries: first snapshot held stable, second dropped, o_dropped=1; i_clrDropped -> 0.
REQ-043 Change exp 3->1 at t=5: current window completes at 8 cycles with o_pktExp=3; the next window is 2 cycles with o_pktExp=1.
REQ-044 Async i_rst at t=3 with o_pktValid=1: all outputs 0 immediately; after release with enable=1, PRIME occurs then RUN.
REQ-045 i_cg=0 for 5 cycles mid-window: o_t and the handshake are frozen, and the window completes 5 cycles later than otherwise.
